pc_sequencer: RTL and testbench

//  Program-counter stage directly downstream of the branch decision logic. Consumes PCSrc/target
//  (eN) plus call/return strobes, holds the architectural PC, and produces the next fetch address.

---
 rtl/pc_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter stage that sits directly after the branch decision logic.
//   Holds the architectural PC, applies redirects, calls and returns, and owns
//   the return-address storage so all call/return state lives in one place.
//
//   Build option (macro PCSEQ_RAS_EN):
//     defined   -> circular return-address stack of RAS_DEPTH entries
//     undefined -> single link register (effective depth 1, RAS_DEPTH unused
//                  except for the width of the debug count)
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     stall             hold PC and return storage this cycle
//     halt_req          enter HALT (exit only by reset)
//     pc_src, target    redirect request and address from the branch stage
//     is_call, is_ret   call (with pc_src) / return strobes
//     pc, pc_valid      fetch address and its qualifier (valid only in RUN)
//     halted            sequencer is in HALT
//     ras_empty/full    return storage occupancy flags (registered)
//     ras_err           sticky overflow/underflow flag
//     dbg_state_o       FSM state (0 BOOT, 1 RUN, 2 HALT)
//     dbg_ras_count_o   number of valid return entries
//
//   Update rule (RUN, stall=0), highest priority first:
//     return with entry -> pop; return when empty -> target + underflow;
//     redirect -> target, push pc+1 if call; otherwise pc+1 (wraps).
module pc_sequencer #(
  parameter int unsigned     PC_W      = 8,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           halt_req,
  input  logic                           pc_src,
  input  logic [PC_W-1:0]                target,
  input  logic                           is_call,
  input  logic                           is_ret,
  output logic [PC_W-1:0]                pc,
  output logic                           pc_valid,
  output logic                           halted,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_err,
  output logic [1:0]                     dbg_state_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] dbg_ras_count_o
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            pc_valid_q;
  logic            halted_q;
  logic            ras_empty_q;
  logic            ras_full_q;
  logic            ras_err_q;

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            advance;
  logic            push;
  logic            pop;
  logic            err_set;
  logic [PC_W-1:0] top_val;
  logic            stk_empty;
  logic            stk_full;
  logic            empty_d;
  logic            full_d;

  assign pc_inc  = pc_q + PC_W'(1);
  assign advance = (state_q == ST_RUN) && !stall;

  // Next-PC selection and return-storage operations for this edge.
  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (advance) begin
      if (is_ret) begin
        if (!stk_empty) begin
          pc_d = top_val;
          pop  = 1'b1;
        end else begin
          pc_d    = target;
          err_set = 1'b1;
        end
      end else if (pc_src) begin
        pc_d = target;
        if (is_call) begin
          push    = 1'b1;
          err_set = stk_full;
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

`ifdef PCSEQ_RAS_EN
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] top_q;
  logic [PtrW-1:0] top_inc;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign top_inc   = top_q + PtrW'(1);
  assign top_val   = ras_q[top_q];
  assign stk_empty = (cnt_q == '0);
  assign stk_full  = (cnt_q == CntW'(RAS_DEPTH));

  // A push on a full stack overwrites the oldest entry; count saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !stk_full) cnt_d = cnt_q + CntW'(1);
    else if (pop)          cnt_d = cnt_q - CntW'(1);
  end

  assign empty_d         = (cnt_d == '0);
  assign full_d          = (cnt_d == CntW'(RAS_DEPTH));
  assign dbg_ras_count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        ras_q[top_inc] <= pc_inc;
        top_q          <= top_inc;
      end else if (pop) begin
        top_q <= top_q - PtrW'(1);
      end
    end
  end
`else
  logic [PC_W-1:0] link_q;
  logic            link_valid_q;

  assign top_val         = link_q;
  assign stk_empty       = !link_valid_q;
  assign stk_full        = link_valid_q;
  assign empty_d         = !(push || (link_valid_q && !pop));
  assign full_d          = !empty_d;
  assign dbg_ras_count_o = CntW'(link_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q       <= '0;
      link_valid_q <= 1'b0;
    end else if (push) begin
      link_q       <= pc_inc;
      link_valid_q <= 1'b1;
    end else if (pop) begin
      link_valid_q <= 1'b0;
    end
  end
`endif

  // Sequencer FSM with registered outputs. The HALT-entry edge still applies
  // the normal RUN update to the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      ras_empty_q <= 1'b1;
      ras_full_q  <= 1'b0;
      ras_err_q   <= 1'b0;
    end else begin
      ras_empty_q <= empty_d;
      ras_full_q  <= full_d;
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          pc_q <= pc_d;
          if (err_set) ras_err_q <= 1'b1;
          if (halt_req) begin
            state_q    <= ST_HALT;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q    <= ST_HALT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b1;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign halted      = halted_q;
  assign ras_empty   = ras_empty_q;
  assign ras_full    = ras_full_q;
  assign ras_err     = ras_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Inputs are driven 1ns after the
// rising edge and outputs are sampled at the same point, so each step()
// observes the result of exactly one clock edge.
module tb_pc_sequencer;

  localparam int PC_W = 8;
`ifdef PCSEQ_RAS_EN
  localparam int NRET = 4;
  localparam logic FULL_ONE = 1'b0;
`else
  localparam int NRET = 1;
  localparam logic FULL_ONE = 1'b1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, halt_req, pc_src, is_call, is_ret;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic            pc_valid, halted, ras_empty, ras_full, ras_err;
  logic [1:0]      dbg_state;
  logic [2:0]      dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [PC_W-1:0] exp_q[$];

  pc_sequencer #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt_req(halt_req),
    .pc_src(pc_src), .target(target), .is_call(is_call), .is_ret(is_ret),
    .pc(pc), .pc_valid(pc_valid), .halted(halted), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_err(ras_err), .dbg_state_o(dbg_state),
    .dbg_ras_count_o(dbg_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt_req = 0; pc_src = 0; is_call = 0; is_ret = 0; target = '0;
  endtask

  // Leaves the DUT in BOOT, 1ns after an edge.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // driver: one plain redirect (no call)
  task automatic go_to(input logic [PC_W-1:0] a);
    pc_src = 1; target = a; step(); pc_src = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #12;
    n_checks++; if (pc !== 8'd0) begin n_errors++; $display("FAIL reset_pc: got %0d expected 0", pc); end
    n_checks++; if (pc_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    n_checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin n_errors++; $display("FAIL reset_flags: got %b expected 100", {ras_empty, ras_full, ras_err}); end
    n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_sequence();
    do_reset();
    n_checks++; if (pc !== 8'd0 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL boot_bubble: got pc=%0d valid=%b expected pc=0 valid=0", pc, pc_valid); end
    for (int i = 0; i < 4; i++) exp_q.push_back(PC_W'(i));
    while (exp_q.size() > 0) begin
      logic [PC_W-1:0] e;
      e = exp_q.pop_front();
      step();
      n_checks++; if (pc !== e || pc_valid !== 1'b1) begin n_errors++; $display("FAIL seq_pc: got pc=%0d valid=%b expected pc=%0d valid=1", pc, pc_valid, e); end
    end
  endtask

  task automatic test_wrap();
    go_to(8'hFF);
    n_checks++; if (pc !== 8'hFF) begin n_errors++; $display("FAIL wrap_setup: got %h expected ff", pc); end
    step();
    n_checks++; if (pc !== 8'h00) begin n_errors++; $display("FAIL wrap_pc: got %h expected 00", pc); end
    n_checks++; if (ras_err !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %b expected 0", ras_err); end
  endtask

  task automatic test_call_ret();
    go_to(8'd5);
    pc_src = 1; is_call = 1; target = 8'd40; step(); clear_inputs();
    n_checks++; if (pc !== 8'd40) begin n_errors++; $display("FAIL call_pc: got %0d expected 40", pc); end
    n_checks++; if (ras_empty !== 1'b0 || ras_full !== FULL_ONE) begin n_errors++; $display("FAIL call_flags: got empty=%b full=%b expected empty=0 full=%b", ras_empty, ras_full, FULL_ONE); end
    step(); step();
    n_checks++; if (pc !== 8'd42) begin n_errors++; $display("FAIL call_body: got %0d expected 42", pc); end
    is_ret = 1; target = 8'd77; step(); clear_inputs();
    n_checks++; if (pc !== 8'd6 || ras_empty !== 1'b1) begin n_errors++; $display("FAIL ret_pc: got pc=%0d empty=%b expected pc=6 empty=1", pc, ras_empty); end
  endtask

  task automatic test_priority();
    // call without pc_src: sequential, nothing stored
    is_call = 1; step(); clear_inputs();
    n_checks++; if (pc !== 8'd7 || ras_empty !== 1'b1) begin n_errors++; $display("FAIL call_no_src: got pc=%0d empty=%b expected pc=7 empty=1", pc, ras_empty); end
    // one entry (8), then return + redirect + call together: return wins
    pc_src = 1; is_call = 1; target = 8'd100; step();
    is_ret = 1; target = 8'd150; step(); clear_inputs();
    n_checks++; if (pc !== 8'd8 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin n_errors++; $display("FAIL ret_wins: got pc=%0d empty=%b err=%b expected pc=8 empty=1 err=0", pc, ras_empty, ras_err); end
  endtask

  task automatic test_nested();
    logic [PC_W-1:0] exp_ret [4];
    exp_ret[0] = 8'd51; exp_ret[1] = 8'd41; exp_ret[2] = 8'd31; exp_ret[3] = 8'd21;
    do_reset(); step();
    go_to(8'd10);
    for (int c = 0; c < 5; c++) begin
      pc_src = 1; is_call = 1; target = PC_W'(20 + 10 * c); step();
      if (c == 0) begin
        n_checks++; if (ras_err !== 1'b0) begin n_errors++; $display("FAIL nest_first_err: got %b expected 0", ras_err); end
      end
    end
    clear_inputs();
    n_checks++; if (pc !== 8'd60 || ras_err !== 1'b1 || ras_full !== 1'b1) begin n_errors++; $display("FAIL nest_overflow: got pc=%0d err=%b full=%b expected pc=60 err=1 full=1", pc, ras_err, ras_full); end
    for (int r = 0; r < NRET; r++) begin
      is_ret = 1; target = 8'd200; step();
      n_checks++; if (pc !== exp_ret[r]) begin n_errors++; $display("FAIL nest_ret%0d: got %0d expected %0d", r, pc, exp_ret[r]); end
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_errors++; $display("FAIL nest_empty: got %b expected 1", ras_empty); end
    is_ret = 1; target = 8'd99; step(); clear_inputs();
    n_checks++; if (pc !== 8'd99 || ras_err !== 1'b1) begin n_errors++; $display("FAIL underflow: got pc=%0d err=%b expected pc=99 err=1", pc, ras_err); end
  endtask

  task automatic test_stall();
    do_reset(); step();
    go_to(8'd50);
    stall = 1; pc_src = 1; is_call = 1; target = 8'd7;
    for (int s = 0; s < 3; s++) begin
      step();
      n_checks++; if (pc !== 8'd50 || ras_empty !== 1'b1) begin n_errors++; $display("FAIL stall_hold%0d: got pc=%0d empty=%b expected pc=50 empty=1", s, pc, ras_empty); end
    end
    stall = 0; is_call = 0; step(); clear_inputs();
    n_checks++; if (pc !== 8'd7) begin n_errors++; $display("FAIL stall_release: got %0d expected 7", pc); end
  endtask

  task automatic test_halt();
    go_to(8'd12);
    halt_req = 1; step(); halt_req = 0;
    n_checks++; if (pc !== 8'd13 || halted !== 1'b1 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL halt_entry: got pc=%0d halted=%b valid=%b expected pc=13 halted=1 valid=0", pc, halted, pc_valid); end
    n_checks++; if (dbg_state !== 2'd2) begin n_errors++; $display("FAIL halt_state: got %0d expected 2", dbg_state); end
    pc_src = 1; is_call = 1; target = 8'd77; step(); step(); clear_inputs();
    n_checks++; if (pc !== 8'd13 || halted !== 1'b1 || ras_empty !== 1'b1) begin n_errors++; $display("FAIL halt_frozen: got pc=%0d halted=%b empty=%b expected pc=13 halted=1 empty=1", pc, halted, ras_empty); end
  endtask

  task automatic test_reset_mid_call();
    do_reset(); step();
    pc_src = 1; is_call = 1; target = 8'd30; step(); clear_inputs();
    n_checks++; if (pc !== 8'd30 || ras_empty !== 1'b0) begin n_errors++; $display("FAIL midrst_setup: got pc=%0d empty=%b expected pc=30 empty=0", pc, ras_empty); end
    #2 rst_n = 0;
    #1;
    n_checks++; if (pc !== 8'd0 || ras_empty !== 1'b1 || pc_valid !== 1'b0) begin n_errors++; $display("FAIL midrst: got pc=%0d empty=%b valid=%b expected pc=0 empty=1 valid=0", pc, ras_empty, pc_valid); end
    do_reset(); step();
    is_ret = 1; target = 8'd44; step(); clear_inputs();
    n_checks++; if (pc !== 8'd44 || ras_err !== 1'b1) begin n_errors++; $display("FAIL midrst_discard: got pc=%0d err=%b expected pc=44 err=1", pc, ras_err); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_call_ret();
    test_priority();
    test_nested();
    test_stall();
    test_halt();
    test_reset_mid_call();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
